// File: rtl/mvm_stream_driver_pkg.sv
// Shared types and constants for the matrix-vector multiply stream driver.
// Slot map: 0-8 hold M row-major, 9-11 hold v[0..2].
package mvm_stream_driver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT,
    COLLECT,
    FINISH
  } state_t;

  localparam int N_OPERANDS = 12;
  localparam int N_RESULTS  = 3;
  localparam int MAT_DIM    = 3;
  localparam int ADDR_W     = 4;

  localparam logic [ADDR_W-1:0] SLOT_M_FIRST = 4'd0;
  localparam logic [ADDR_W-1:0] SLOT_M_LAST  = 4'd8;
  localparam logic [ADDR_W-1:0] SLOT_V_FIRST = 4'd9;
  localparam logic [ADDR_W-1:0] SLOT_V_LAST  = 4'd11;

  function automatic logic slot_valid(input logic [ADDR_W-1:0] addr);
    return addr <= SLOT_V_LAST;
  endfunction

endpackage

// File: rtl/mvm_operand_buffer.sv
// 12-entry operand register file: one write port, one combinational read port.
// Out-of-range addresses are dropped on write and read back as zero.
module mvm_operand_buffer
  import mvm_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [N_OPERANDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_OPERANDS; i++) mem[i] <= '0;
    end else if (we && slot_valid(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = slot_valid(raddr) ? mem[raddr] : '0;

endmodule

// File: rtl/mvm_stream_driver.sv
// Streams 12 buffered operands to a 3x3 matrix-vector multiplier and captures
// up to 3 result words, with a bounded wait for the first result.
module mvm_stream_driver
  import mvm_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_we,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  go,
  output logic                  busy,
  output logic                  mvm_start,
  output logic [DATA_WIDTH-1:0] mvm_data,
  input  logic                  mvm_done,
  input  logic [DATA_WIDTH-1:0] mvm_y,
  input  logic [1:0]            res_addr,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  output logic                  timeout_err,
  output state_t                state_dbg
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [1:0] CAP_LAST = 2'(N_RESULTS - 1);

  state_t                state_q, state_nx;
  logic [ADDR_W-1:0]     slot_q, slot_nx;
  logic [WAIT_W-1:0]     wait_q, wait_nx;
  logic [1:0]            cap_q, cap_nx;
  logic                  valid_q, valid_nx;
  logic                  terr_q, terr_nx;
  logic                  cap_we;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic [DATA_WIDTH-1:0] res_q [N_RESULTS];

  mvm_operand_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_operand_buffer (
    .clk  (clk),
    .reset(reset),
    .we   (buf_we),
    .waddr(ld_addr),
    .wdata(ld_data),
    .raddr(slot_q),
    .rdata(buf_rdata)
  );

  // Multiplier protocol: mvm_start pulses once, operand slot k follows k cycles
  // later, and each result word is qualified by mvm_done in its own cycle.
  always_comb begin
    state_nx = state_q;
    slot_nx  = slot_q;
    wait_nx  = wait_q;
    cap_nx   = cap_q;
    valid_nx = valid_q;
    terr_nx  = terr_q;
    cap_we   = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        buf_we = ld_we;
        if (go) begin
          state_nx = START;
          slot_nx  = SLOT_M_FIRST;
          cap_nx   = 2'd0;
          valid_nx = 1'b0;
          terr_nx  = 1'b0;
        end
      end
      START: begin
        state_nx = SEND;
        slot_nx  = SLOT_M_FIRST + 4'd1;
      end
      SEND: begin
        if (slot_q == SLOT_V_LAST) begin
          state_nx = WAIT;
          wait_nx  = '0;
        end else begin
          slot_nx = slot_q + 4'd1;
        end
      end
      WAIT: begin
        if (mvm_done) begin
          cap_we   = 1'b1;
          cap_nx   = 2'd1;
          state_nx = COLLECT;
        end else if (wait_q == WAIT_LAST) begin
          terr_nx  = 1'b1;
          state_nx = FINISH;
        end else begin
          wait_nx = wait_q + 1'b1;
        end
      end
      COLLECT: begin
        if (!mvm_done) begin
          state_nx = FINISH;
        end else begin
          cap_we = 1'b1;
          cap_nx = cap_q + 2'd1;
          // Third word completes the run; any further done is never sampled.
          if (cap_q == CAP_LAST) begin
            state_nx = FINISH;
            valid_nx = 1'b1;
          end
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q  <= '0;
      wait_q  <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      for (int i = 0; i < N_RESULTS; i++) res_q[i] <= '0;
    end else begin
      slot_q  <= slot_nx;
      wait_q  <= wait_nx;
      cap_q   <= cap_nx;
      valid_q <= valid_nx;
      terr_q  <= terr_nx;
      if (cap_we) res_q[cap_q] <= mvm_y;
    end
  end

  assign busy        = (state_q != IDLE);
  assign mvm_start   = (state_q == START);
  assign mvm_data    = (state_q == START || state_q == SEND) ? buf_rdata : '0;
  assign res_valid   = valid_q;
  assign timeout_err = terr_q;
  assign res_data    = (res_addr < 2'(N_RESULTS)) ? res_q[res_addr] : '0;
  assign state_dbg   = state_q;

endmodule
